// File: rtl/mux_2to1_m.sv
// mux_2to1_m
// Word-wide 2-to-1 multiplexer for the processor datapath. It has two outputs:
// a combinational select for same-cycle use, and a clocked, enable-gated copy
// with a sticky valid flag for use at pipeline-stage boundaries.
//
// Ports:
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous active-low reset (clears Y_q / Y_valid only)
//   A       in   DWIDTH  word selected when sel = 0
//   B       in   DWIDTH  word selected when sel = 1
//   sel     in   1       select: 0 -> A, 1 -> B
//   en      in   1       capture enable for the registered path
//   Y       out  DWIDTH  combinational selected word
//   Y_q     out  DWIDTH  registered selected word
//   Y_valid out  1       set once Y_q holds a captured word since reset

module mux_2to1_m #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic              sel,
    input  logic              en,
    output logic [DWIDTH-1:0] Y,
    output logic [DWIDTH-1:0] Y_q,
    output logic              Y_valid
);

    // The conditional operator is kept deliberately: with an unknown sel it
    // yields the common bits of A and B and X elsewhere, which an if/else or
    // case form would not reproduce.
    assign Y = sel ? B : A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q     <= '0;
            Y_valid <= 1'b0;
        end else if (en) begin
            Y_q     <= Y;
            Y_valid <= 1'b1;   // sticky until the next reset
        end
    end

endmodule

// File: tb/tb_mux_2to1_m.sv
module tb_mux_2to1_m;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        sel;
    logic        en;
    logic [31:0] Y;
    logic [31:0] Y_q;
    logic        Y_valid;

    int checks = 0;
    int errors = 0;

    logic probe;
    logic four_state;

    mux_2to1_m #(.DWIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .sel     (sel),
        .en      (en),
        .Y       (Y),
        .Y_q     (Y_q),
        .Y_valid (Y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        probe      = 1'bx;
        four_state = (probe === 1'bx);

        // Reset state
        rst_n = 1'b0; en = 1'b0; sel = 1'b0; A = '0; B = '0;
        #1;
        chk("reset_yq",    Y_q,            32'h0000_0000);
        chk("reset_valid", {31'd0, Y_valid}, 32'd0);

        // Combinational select, first word pair
        A = 32'hFFFF_FFFF; B = 32'hEEEE_EEEE; sel = 1'b0;
        #10;
        chk("comb1_sel0", Y, 32'hFFFF_FFFF);
        sel = 1'b1;
        #10;
        chk("comb1_sel1", Y, 32'hEEEE_EEEE);

        // Second pair, changed and checked within one half-cycle (no edge)
        @(posedge clk); #1;
        A = 32'h0123_4567; B = 32'hFEDC_BA98; sel = 1'b0;
        #1;
        chk("comb2_sel0", Y, 32'h0123_4567);
        sel = 1'b1;
        #1;
        chk("comb2_sel1", Y, 32'hFEDC_BA98);

        // Release reset with en low: nothing captured
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; sel = 1'b0;
        @(posedge clk); #1;
        chk("noen_yq",    Y_q,              32'h0000_0000);
        chk("noen_valid", {31'd0, Y_valid}, 32'd0);

        // First capture
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        chk("cap0_yq",    Y_q,              32'h0123_4567);
        chk("cap0_valid", {31'd0, Y_valid}, 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_yq",    Y_q,              32'h0000_0000);
        chk("areset_valid", {31'd0, Y_valid}, 32'd0);
        chk("areset_y0",    Y,                32'h0123_4567);
        sel = 1'b1;
        #1;
        chk("areset_y1",    Y,                32'hFEDC_BA98);
        @(posedge clk); #1;
        chk("areset_hold_yq", Y_q,            32'h0000_0000);

        // Registered capture, back-to-back
        @(negedge clk);
        rst_n = 1'b1; sel = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        chk("cap1_yq",    Y_q,              32'h0123_4567);
        chk("cap1_valid", {31'd0, Y_valid}, 32'd1);
        @(negedge clk);
        sel = 1'b1;
        @(posedge clk); #1;
        chk("cap2_yq",    Y_q,              32'h FEDC_BA98);

        // Enable hold over three edges
        @(negedge clk);
        en = 1'b0; sel = 1'b0; A = 32'h1111_1111; B = 32'h2222_2222;
        #1;
        chk("hold1_y", Y, 32'h1111_1111);
        @(posedge clk); #1;
        chk("hold1_yq",    Y_q,              32'hFEDC_BA98);
        chk("hold1_valid", {31'd0, Y_valid}, 32'd1);
        @(negedge clk);
        sel = 1'b1; A = 32'h3333_3333; B = 32'h4444_4444;
        #1;
        chk("hold2_y", Y, 32'h4444_4444);
        @(posedge clk); #1;
        chk("hold2_yq",    Y_q,              32'hFEDC_BA98);
        chk("hold2_valid", {31'd0, Y_valid}, 32'd1);
        @(negedge clk);
        sel = 1'b0; A = 32'h5555_5555; B = 32'h6666_6666;
        #1;
        chk("hold3_y", Y, 32'h5555_5555);
        @(posedge clk); #1;
        chk("hold3_yq",    Y_q,              32'hFEDC_BA98);
        chk("hold3_valid", {31'd0, Y_valid}, 32'd1);

        // Unknown select
        @(negedge clk);
        sel = 1'bx; A = 32'h5A5A_5A5A; B = 32'h5A5A_5A5A;
        #1;
        chk("selx_agree", Y, 32'h5A5A_5A5A);
        A = 32'h0000_0000; B = 32'hFFFF_FFFF;
        #1;
        if (four_state)
            chk("selx_differ", Y, {32{1'bx}});
        else
            // Two-state simulators resolve X to a definite value: Y must be one input
            chk("selx_differ", {31'd0, (Y === A) || (Y === B)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
